fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Parametrised read-side controller for the asynchronous FIFO, successor to the fixed-width read/empty block. Runs entirely in the read clock domain. Consumes the write pointer after it has passed through the external 2-flop synchronizer, and produces:
- the read RAM address and the Gray read pointer, which is sent to the write domain;
- a registered empty flag;
- a registered fill level and an almost-empty flag;
- a sticky underflow error.

## Interface
Parameters:
- ADDR_W, 4, address width; FIFO depth is 2**ADDR_W; pointers are ADDR_W+1 bits.
- AE_THRESH, 2, almost-empty threshold in words; legal range 0..2**ADDR_W.

Ports:
- clk  in  1  read-domain clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rinc  in  1  read request; one word per cycle while high.
- rq2_wptr  in  ADDR_W+1  Gray write pointer, already synchronized into clk domain.
- rerr_clr  in  1  clears the sticky underflow flag.
- radr  out  ADDR_W  binary RAM read address.
- rptr  out  ADDR_W+1  Gray read pointer, registered; goes to the write-domain synchronizer.
- rempty  out  1  FIFO empty, registered.
- raempty  out  1  level <= AE_THRESH, registered.
- rlevel  out  ADDR_W+1  words available, 0..2**ADDR_W, registered.
- rerr  out  1  sticky underflow flag.

## Operation
- **State:** binary counter rbin[ADDR_W:0], registered rptr, rempty, raempty, rlevel, rerr.
- **Addressing:** radr = rbin[ADDR_W-1:0]; driven directly from the register, no combinational path from inputs.
- **Read acceptance:** rd_ok = rinc & ~rempty.
  - rbin_next = rbin + rd_ok, modulo 2**(ADDR_W+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
- **Per rising edge:**
  - rbin <= rbin_next
  - rptr <= rgray_next
  - rempty <= (rgray_next == rq2_wptr)
- **Fill level:**
  - wbin = Gray-to-binary(rq2_wptr), computed by XOR prefix from the MSB.
  - level_next = (wbin - rbin_next) modulo 2**(ADDR_W+1).
  - rlevel <= level_next.
  - raempty <= (level_next <= AE_THRESH).
- **Underflow:**
  - rinc & rempty leaves the pointers unchanged, and rerr <= 1.
  - rerr holds until a cycle with rerr_clr=1 and no new underflow.
  - Simultaneous underflow and rerr_clr: set wins, rerr stays 1.
- **Reset values (asynchronous):**
  - rbin=0, rptr=0, radr=0
  - rempty=1, raempty=1
  - rlevel=0, rerr=0
- **Wrap-around:**
  - The extra MSB distinguishes 0 from 2**ADDR_W words.
  - rlevel=2**ADDR_W when wbin = rbin ^ (1<<ADDR_W).
- **Out-of-range input:** rlevel > 2**ADDR_W indicates corrupted synchronizer input. It is not checked; behaviour is undefined.

## Timing
- **Read data:** the RAM word at radr is valid in the cycle rinc is sampled. radr advances on the same edge that accepts the read.
- **Last word:** reading the last word asserts rempty on that same edge (zero-cycle lag); no over-read is possible.
- **Empty deassertion:** a change in rq2_wptr deasserts rempty and updates rlevel/raempty at the next rising edge, i.e. 1 cycle after rq2_wptr changes. The external synchronizer adds 2 more cycles.
- **rptr output:** changes only on rising edges, by at most one Gray bit per edge.
- **Reset during activity:**
  - Mid-burst rst_n assertion forces the reset values immediately, without a clock edge.
  - Deassertion must be synchronized externally to clk.
  - The write side must be reset together with this block.

## Configuration
- **Macro:** FIFO_RD_LEVEL_EN.
- **Defined:**
  - The Gray-to-binary converter, level subtractor and threshold compare are compiled in.
  - rlevel and raempty behave as specified above.
- **Undefined:**
  - That logic is removed.
  - rlevel is tied to 0.
  - raempty equals rempty.
  - rempty, rptr, radr and rerr are unchanged.

## Test plan
All scenarios use ADDR_W=3, AE_THRESH=2, macro defined unless stated.

1. **Reset:** hold rst_n=0 with rinc=1 and rq2_wptr=4'b0111 → rptr=0, radr=0, rempty=1, raempty=1, rlevel=0, rerr=0.
2. **Fill then drain:**
   - Set rq2_wptr=gray(5)=4'b0111 → next edge: rempty=0, rlevel=5, raempty=0.
   - Then 5 consecutive rinc pulses → radr 0,1,2,3,4; rlevel 4,3,2,1,0; raempty=1 from level 2; rempty=1 on the 5th edge; rptr=4'b0111.
3. **Underflow:**
   - From empty, rinc=1 for 1 cycle → rptr unchanged, rerr=1 next edge; rerr holds for 10 idle cycles.
   - rinc=1 with rerr_clr=1 → rerr stays 1.
   - rerr_clr alone → rerr=0.
4. **Full and wrap:**
   - With rptr=0, set rq2_wptr=gray(8)=4'b1100 → rempty=0, rlevel=8.
   - 8 reads → radr wraps 7→0, rempty=1, rptr=4'b1100.
   - Continue to binary count 15 → rptr=4'b1000; the next accepted read gives rptr=4'b0000.
5. **Async reset mid-burst:** at rlevel=3 with rinc=1, drop rst_n between edges → all outputs take reset values before the next clk edge; pointers restart from 0 after release.
6. **Macro undefined:** repeat scenario 2 → rlevel=0 throughout; raempty equals rempty on every cycle; radr/rptr/rempty sequence identical to scenario 2.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the async FIFO: read address, Gray read pointer, empty, level and underflow.
// Optional level/almost-empty logic is compiled in with `define FIFO_RD_LEVEL_EN.
module fifo_read_ctrl #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rinc_i,
  input  logic [ADDR_W:0]   rq2_wptr_i,
  input  logic              rerr_clr_i,
  output logic [ADDR_W-1:0] radr_o,
  output logic [ADDR_W:0]   rptr_o,
  output logic              rempty_o,
  output logic              raempty_o,
  output logic [ADDR_W:0]   rlevel_o,
  output logic              rerr_o
);

  localparam int unsigned PW = ADDR_W + 1;

  if (AE_THRESH > (2 ** ADDR_W)) begin : g_bad_thresh
    $error("fifo_read_ctrl: AE_THRESH exceeds FIFO depth");
  end

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rgray_d;
  logic          rempty_q, rempty_d;
  logic          rerr_q, rerr_d;
  logic          rd_ok, underflow;

  always_comb begin
    rd_ok     = rinc_i & ~rempty_q;
    underflow = rinc_i & rempty_q;
    rbin_d    = rbin_q + {{ADDR_W{1'b0}}, rd_ok};
    rgray_d   = rbin_d ^ (rbin_d >> 1);
    rempty_d  = (rgray_d == rq2_wptr_i);
    // a new underflow takes priority over a clear in the same cycle
    if (underflow)
      rerr_d = 1'b1;
    else if (rerr_clr_i)
      rerr_d = 1'b0;
    else
      rerr_d = rerr_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rerr_q   <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      rempty_q <= rempty_d;
      rerr_q   <= rerr_d;
    end
  end

  assign radr_o   = rbin_q[ADDR_W-1:0];
  assign rptr_o   = rptr_q;
  assign rempty_o = rempty_q;
  assign rerr_o   = rerr_q;

`ifdef FIFO_RD_LEVEL_EN
  localparam logic [PW:0] AE_T = AE_THRESH[PW:0];

  logic [PW-1:0] wbin;
  logic [PW-1:0] level_d, rlevel_q;
  logic          raempty_d, raempty_q;

  always_comb begin
    wbin[PW-1] = rq2_wptr_i[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr_i[i];
    end
    // extra MSB makes a full FIFO read as 2**ADDR_W rather than 0
    level_d   = wbin - rbin_d;
    raempty_d = ({1'b0, level_d} <= AE_T);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rlevel_q  <= '0;
      raempty_q <= 1'b1;
    end else begin
      rlevel_q  <= level_d;
      raempty_q <= raempty_d;
    end
  end

  assign rlevel_o  = rlevel_q;
  assign raempty_o = raempty_q;
`else
  assign rlevel_o  = '0;
  assign raempty_o = rempty_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl (ADDR_W=3, AE_THRESH=2): directed scenarios plus random traffic
// against a word-count model of the FIFO read side.
module tb_fifo_read_ctrl;

  localparam int AW = 3;
  localparam int PW = AW + 1;
  localparam int AE = 2;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          rinc;
  logic [PW-1:0] rq2_wptr;
  logic          rerr_clr;
  logic [AW-1:0] radr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic          raempty;
  logic [PW-1:0] rlevel;
  logic          rerr;

  fifo_read_ctrl #(.ADDR_W(AW), .AE_THRESH(AE)) dut (
    .clk_i      (clk_sys),
    .rst_n_i    (rst_n),
    .rinc_i     (rinc),
    .rq2_wptr_i (rq2_wptr),
    .rerr_clr_i (rerr_clr),
    .radr_o     (radr),
    .rptr_o     (rptr),
    .rempty_o   (rempty),
    .raempty_o  (raempty),
    .rlevel_o   (rlevel),
    .rerr_o     (rerr)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  // model: total words read / made visible by the write side, as plain counts
  int rd_cnt, wr_cnt, m_lvl;
  bit m_empty, m_err;

  function automatic logic [PW-1:0] gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_w(input int w);
    wr_cnt   = w;
    rq2_wptr = gray(w);
  endtask

  task automatic check_all();
    check_eq("radr", 32'(radr), 32'(rd_cnt % 8));
    check_eq("rptr", 32'(rptr), 32'(gray(rd_cnt)));
    check_eq("rempty", 32'(rempty), 32'(m_empty));
    check_eq("rerr", 32'(rerr), 32'(m_err));
`ifdef FIFO_RD_LEVEL_EN
    check_eq("rlevel", 32'(rlevel), 32'(m_lvl));
    check_eq("raempty", 32'(raempty), 32'(m_lvl <= AE));
`else
    check_eq("rlevel", 32'(rlevel), 32'd0);
    check_eq("raempty", 32'(raempty), 32'(m_empty));
`endif
  endtask

  task automatic step();
    bit und;
    @(posedge clk_sys);
    und = rinc && m_empty;
    if (rinc && !m_empty) rd_cnt++;
    if (und) m_err = 1'b1;
    else if (rerr_clr) m_err = 1'b0;
    m_empty = (rd_cnt == wr_cnt);
    m_lvl   = wr_cnt - rd_cnt;
    #1 check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rptr"}, 32'(rptr), 32'd0);
    check_eq({tag, "_radr"}, 32'(radr), 32'd0);
    check_eq({tag, "_rempty"}, 32'(rempty), 32'd1);
    check_eq({tag, "_raempty"}, 32'(raempty), 32'd1);
    check_eq({tag, "_rlevel"}, 32'(rlevel), 32'd0);
    check_eq({tag, "_rerr"}, 32'(rerr), 32'd0);
  endtask

  // assert reset between edges, check immediately, then release on a falling edge
  task automatic do_reset(input string tag);
    #3 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    rinc     = 1'b0;
    rerr_clr = 1'b0;
    rd_cnt = 0; m_lvl = 0; m_empty = 1'b1; m_err = 1'b0;
    set_w(0);
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rinc     = 1'b1;
    rerr_clr = 1'b0;
    rq2_wptr = 4'b0111;
    repeat (3) @(posedge clk_sys);
    #1 check_reset_vals("rst_hold");
    rinc = 1'b0;
    rd_cnt = 0; m_lvl = 0; m_empty = 1'b1; m_err = 1'b0;
    set_w(0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    step();

    // fill to 5 then drain
    set_w(5);
    step();
    rinc = 1'b1;
    repeat (5) step();
    rinc = 1'b0;
    check_eq("drain_rptr", 32'(rptr), 32'b0111);
    step();

    // underflow, hold, clear-vs-set priority
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    repeat (10) step();
    rinc = 1'b1; rerr_clr = 1'b1;
    step();
    rinc = 1'b0;
    step();
    rerr_clr = 1'b0;
    step();

    // full and wrap
    do_reset("rst_pulse");
    step();
    set_w(8);
    step();
    rinc = 1'b1;
    repeat (8) step();
    check_eq("full_rptr", 32'(rptr), 32'b1100);
    rinc = 1'b0;
    set_w(15);
    step();
    rinc = 1'b1;
    repeat (7) step();
    check_eq("bin15_rptr", 32'(rptr), 32'b1000);
    rinc = 1'b0;
    set_w(16);
    step();
    rinc = 1'b1;
    step();
    check_eq("wrap0_rptr", 32'(rptr), 32'b0000);
    rinc = 1'b0;
    step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rinc     = ($urandom_range(0, 99) < 55);
      rerr_clr = ($urandom_range(0, 19) == 0);
      if (wr_cnt - rd_cnt < 8) begin
        if ($urandom_range(0, 15) == 0)
          set_w(rd_cnt + 8);
        else if ($urandom_range(0, 1) == 1)
          set_w(wr_cnt + 1);
      end
      step();
    end
    rinc = 1'b0; rerr_clr = 1'b0;
    step();

    // async reset mid-burst at level 3
    set_w(rd_cnt + 5);
    step();
    rinc = 1'b1;
    repeat (2) step();
    check_eq("pre_rst_level", 32'(rlevel), 32'(`ifdef FIFO_RD_LEVEL_EN 3 `else 0 `endif));
    do_reset("rst_burst");
    step();
    set_w(3);
    step();
    rinc = 1'b1;
    repeat (4) step();
    rinc = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
